// File: rtl/seq_index_generator.sv
// Streaming index generator: on start, emits `count` beats of LANES indices
// spaced by a stride, all reduced modulo SIZE, over a valid/ready handshake.
`timescale 1ns/1ps
module seq_index_generator #(
  parameter int SIZE      = 16,
  parameter int LANES     = 4,
  parameter int MAX_COUNT = 64,
  localparam int W  = $clog2(SIZE),
  localparam int CW = $clog2(MAX_COUNT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       base,
  input  logic [W-1:0]       stride,
  input  logic [CW-1:0]      count,
  output logic [LANES*W-1:0] num_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  localparam logic [W:0]    SIZE_X = (W + 1)'(SIZE);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_COUNT);

  state_e        state_q, state_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  bstep_q, bstep_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  off_q [LANES];
  logic [W-1:0]  off_d [LANES];
  logic [W-1:0]  off_c [LANES];
  logic [W-1:0]  bstep_c;
  logic [W-1:0]  acc;
  logic [W-1:0]  base_red, str_red;
  logic [CW-1:0] cnt_clamped;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SIZE_X) s = s - SIZE_X;
    return s[W-1:0];
  endfunction

  // Inputs are at most 2^W-1 < 2*SIZE, so one conditional subtract reduces them.
  function automatic logic [W-1:0] reduce(input logic [W-1:0] v);
    logic [W:0] x;
    x = {1'b0, v};
    if (x >= SIZE_X) x = x - SIZE_X;
    return x[W-1:0];
  endfunction

  assign base_red    = reduce(base);
  assign str_red     = reduce(stride);
  assign cnt_clamped = (count > MAX_C) ? MAX_C : count;

  // i*str mod SIZE built as a chain of modular adds; the final step is LANES*str.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      off_c[i] = acc;
      acc      = mod_add(acc, str_red);
    end
    bstep_c = acc;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bstep_d = bstep_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          cur_d   = base_red;
          off_d   = off_c;
          bstep_d = bstep_c;
          rem_d   = cnt_clamped;
          if (cnt_clamped != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (out_ready) begin
          cur_d = mod_add(cur_q, bstep_q);
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1)) state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      bstep_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) off_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bstep_q <= bstep_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    num_out = '0;
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < LANES; i++) num_out[i*W +: W] = mod_add(cur_q, off_q[i]);
    end
  end

  assign out_valid = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_index_generator.sv
// Bench for seq_index_generator: directed scenarios plus a randomized sweep
// over several SIZE/LANES configurations, checked against a modulo reference.
`timescale 1ns/1ps
module tb_seq_index_generator;

  localparam int NI   = 13;
  localparam int MAXC = 64;

  function automatic int sz_of(input int g);
    if (g == 12) return 10;
    case (g / 3)
      0: return 2;
      1: return 7;
      2: return 16;
      default: return 100;
    endcase
  endfunction

  function automatic int ln_of(input int g);
    if (g == 12) return 4;
    case (g % 3)
      0: return 1;
      1: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int w_of(input int g);
    return $clog2(sz_of(g));
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  int            sel;
  logic [31:0]   base_w;
  logic [31:0]   stride_w;
  logic [6:0]    count_w;
  logic          ready;
  logic [NI-1:0] valid_a;
  logic [NI-1:0] busy_a;
  logic [NI-1:0] done_a;
  logic [63:0]   nout_a [NI];
  int            rdy_pat [$];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int S  = sz_of(g);
    localparam int L  = ln_of(g);
    localparam int WW = $clog2(S);
    logic [L*WW-1:0] no;
    seq_index_generator #(.SIZE(S), .LANES(L), .MAX_COUNT(MAXC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start && (sel == g)),
      .base      (base_w[WW-1:0]),
      .stride    (stride_w[WW-1:0]),
      .count     (count_w),
      .num_out   (no),
      .out_valid (valid_a[g]),
      .out_ready (ready),
      .busy      (busy_a[g]),
      .done      (done_a[g])
    );
    assign nout_a[g] = 64'(no);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lane i of beat j is (base + (j*LANES + i)*stride) mod SIZE.
  function automatic logic [63:0] exp_beat(input int g, input int b, input int s, input int j);
    int sz, ln, w, bb, ss;
    logic [63:0] r;
    sz = sz_of(g); ln = ln_of(g); w = w_of(g);
    bb = (b & ((1 << w) - 1)) % sz;
    ss = (s & ((1 << w) - 1)) % sz;
    r = '0;
    for (int i = 0; i < ln; i++) r = r | (64'((bb + (j * ln + i) * ss) % sz) << (i * w));
    return r;
  endfunction

  // rmode: 0 always ready, 1 random ready, 2 ready from rdy_pat.
  task automatic run_stream(input int g, input int b, input int s, input int c,
                            input int rmode, input bit poke, input string tag);
    int n, hs, cyc;
    n = (c > MAXC) ? MAXC : c;
    sel = g; base_w = 32'(b); stride_w = 32'(s); count_w = 7'(c); start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      check({tag, "/zc_done"}, 64'(done_a[g]), 64'd1);
      check({tag, "/zc_valid"}, 64'(valid_a[g]), 64'd0);
      check({tag, "/zc_busy"}, 64'(busy_a[g]), 64'd0);
      tick();
      check({tag, "/zc_done_clear"}, 64'(done_a[g]), 64'd0);
      return;
    end
    check({tag, "/first_busy"}, 64'(busy_a[g]), 64'd1);
    hs = 0; cyc = 0;
    while (valid_a[g] === 1'b1 && cyc < 400) begin
      case (rmode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: ready = (rdy_pat.size() > 0) ? 1'(rdy_pat.pop_front()) : 1'b1;
      endcase
      if (poke && cyc == 1) begin
        start = 1'b1; base_w = 32'(b + 5); stride_w = 32'(s + 1); count_w = 7'd9;
      end else begin
        start = 1'b0;
      end
      check({tag, "/beat"}, nout_a[g], exp_beat(g, b, s, hs));
      check({tag, "/busy"}, 64'(busy_a[g]), 64'd1);
      if (ready) hs++;
      tick();
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    check({tag, "/handshakes"}, 64'(hs), 64'(n));
    check({tag, "/done"}, 64'(done_a[g]), 64'd1);
    check({tag, "/valid_off"}, 64'(valid_a[g]), 64'd0);
    check({tag, "/busy_fin"}, 64'(busy_a[g]), 64'd1);
    tick();
    check({tag, "/done_clear"}, 64'(done_a[g]), 64'd0);
    check({tag, "/busy_clear"}, 64'(busy_a[g]), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 0; base_w = '0; stride_w = '0; count_w = '0; ready = 1'b1;
    tick();
    tick();
    check("rst/valid", 64'(valid_a), 64'd0);
    check("rst/busy", 64'(busy_a), 64'd0);
    check("rst/done", 64'(done_a), 64'd0);
    for (int g = 0; g < NI; g++) check("rst/num_out", nout_a[g], 64'd0);
    rst_n = 1'b1;
    tick();

    // Wrap across the top, SIZE=16 LANES=4
    sel = 7; base_w = 14; stride_w = 1; count_w = 2; start = 1'b1;
    tick();
    start = 1'b0;
    check("wrap/beat0", nout_a[7], 64'h10FE);
    check("wrap/valid", 64'(valid_a[7]), 64'd1);
    tick();
    check("wrap/beat1", nout_a[7], 64'h5432);
    tick();
    check("wrap/done", 64'(done_a[7]), 64'd1);
    check("wrap/valid_off", 64'(valid_a[7]), 64'd0);
    tick();

    // Non-power-of-two SIZE=10
    sel = 12; base_w = 8; stride_w = 3; count_w = 3; start = 1'b1;
    tick();
    start = 1'b0;
    check("np2/beat0", nout_a[12], 64'h7418);
    tick();
    check("np2/beat1", nout_a[12], 64'h9630);
    tick();
    check("np2/beat2", nout_a[12], 64'h1852);
    tick();
    check("np2/done", 64'(done_a[12]), 64'd1);
    tick();
    sel = 12; base_w = 12; stride_w = 13; count_w = 3; start = 1'b1;
    tick();
    start = 1'b0;
    check("oversize/beat0", nout_a[12], 64'h1852);
    tick();
    check("oversize/beat1", nout_a[12], 64'h3074);
    tick();
    check("oversize/beat2", nout_a[12], 64'h5296);
    tick();
    tick();
    run_stream(12, 12, 13, 3, 0, 1'b0, "oversize_model");

    // Backpressure with ready pattern 1,0,0,1,1
    rdy_pat = '{1, 0, 0, 1, 1};
    run_stream(7, 0, 2, 3, 2, 1'b0, "bp");

    run_stream(7, 5, 3, 0, 0, 1'b0, "zero16");
    run_stream(12, 9, 7, 0, 0, 1'b0, "zero10");
    run_stream(7, 3, 5, 6, 0, 1'b1, "start_busy");
    run_stream(7, 1, 1, 100, 0, 1'b0, "clamp");

    // Reset mid-stream after the first beat of count=4
    sel = 7; base_w = 3; stride_w = 1; count_w = 4; start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst/beat0", nout_a[7], 64'h6543);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst/valid", 64'(valid_a[7]), 64'd0);
    check("midrst/busy", 64'(busy_a[7]), 64'd0);
    check("midrst/done", 64'(done_a[7]), 64'd0);
    check("midrst/num_out", nout_a[7], 64'd0);
    tick();
    check("midrst/no_done", 64'(done_a[7]), 64'd0);
    run_stream(7, 9, 7, 4, 1, 1'b0, "post_rst");

    for (int g = 0; g < 12; g++) begin
      for (int r = 0; r < 4; r++) begin
        run_stream(g, int'($urandom_range(0, (1 << w_of(g)) - 1)),
                   int'($urandom_range(0, (1 << w_of(g)) - 1)),
                   int'($urandom_range(0, 70)), 1, 1'b0, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
